// File: rtl/ray_gen_scan.sv
// Raster-scan primary-ray generator: issues one pixel per cycle (optionally strided)
// and produces dir = xs*U + ys*V + W through a 3-stage stallable pipeline.
module ray_gen_scan #(
  parameter int WIDTH   = 512,
  parameter int HEIGHT  = 384,
  parameter int XW      = 11,
  parameter int YW      = 10,
  parameter int COORD_W = 24,
  parameter int FRAC    = 8,
  parameter int OUT_W   = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [1:0]         stride_log2_in,
  input  logic [COORD_W-1:0] u_x_in,
  input  logic [COORD_W-1:0] u_y_in,
  input  logic [COORD_W-1:0] u_z_in,
  input  logic [COORD_W-1:0] v_x_in,
  input  logic [COORD_W-1:0] v_y_in,
  input  logic [COORD_W-1:0] v_z_in,
  input  logic [COORD_W-1:0] w_x_in,
  input  logic [COORD_W-1:0] w_y_in,
  input  logic [COORD_W-1:0] w_z_in,
  output logic               busy_out,
  output logic               done_out,
  input  logic               ready_in,
  output logic               valid_out,
  output logic [XW-1:0]      x_out,
  output logic [YW-1:0]      y_out,
  output logic [OUT_W-1:0]   dir_x_out,
  output logic [OUT_W-1:0]   dir_y_out,
  output logic [OUT_W-1:0]   dir_z_out,
  output logic               first_out,
  output logic               last_out
);

  localparam int PX_W  = COORD_W + XW + 1;
  localparam int PY_W  = COORD_W + YW + 1;
  localparam int SUM_W = ((PX_W > PY_W) ? PX_W : PY_W) + 2;
  localparam int EXT_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;

  localparam logic signed [XW:0] HALF_W   = (XW+1)'(WIDTH / 2);
  localparam logic signed [YW:0] HALF_H   = (YW+1)'(HEIGHT / 2);
  localparam logic [XW:0]        WIDTH_L  = (XW+1)'(WIDTH);
  localparam logic [YW:0]        HEIGHT_L = (YW+1)'(HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  // Frame configuration, captured on an accepted start
  logic signed [COORD_W-1:0] cu_x, cu_y, cu_z;
  logic signed [COORD_W-1:0] cv_x, cv_y, cv_z;
  logic signed [COORD_W-1:0] cw_x, cw_y, cw_z;
  logic [1:0]                c_stride;

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [3:0]    step;
  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;
  logic          x_wrap, y_end;
  logic          adv, accept, issue, hs_last;

  // Stage 1: centred coordinates
  logic                s1_valid, s1_first, s1_last;
  logic [XW-1:0]       s1_x;
  logic [YW-1:0]       s1_y;
  logic signed [XW:0]  s1_xs;
  logic signed [YW:0]  s1_ys;

  // Stage 2: full-width products
  logic                   s2_valid, s2_first, s2_last;
  logic [XW-1:0]          s2_x;
  logic [YW-1:0]          s2_y;
  logic signed [PX_W-1:0] s2_px_x, s2_px_y, s2_px_z;
  logic signed [PY_W-1:0] s2_py_x, s2_py_y, s2_py_z;

  function automatic logic [OUT_W-1:0] shift_dir(
    input logic signed [PX_W-1:0]    px,
    input logic signed [PY_W-1:0]    py,
    input logic signed [COORD_W-1:0] w
  );
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(px) + SUM_W'(py) + SUM_W'(w);
    // Sign-extend before the arithmetic shift so the floor holds when SUM_W-FRAC < OUT_W
    return OUT_W'(EXT_W'(s) >>> FRAC);
  endfunction

  always_comb begin
    adv     = !(valid_out && !ready_in);
    step    = 4'd1 << c_stride;
    x_sum   = {1'b0, x_cnt} + (XW+1)'(step);
    y_sum   = {1'b0, y_cnt} + (YW+1)'(step);
    x_wrap  = (x_sum >= WIDTH_L);
    y_end   = (y_sum >= HEIGHT_L);
    // done_out high means the FSM has only just returned to IDLE; hold off one cycle
    accept  = (state == IDLE) && start_in && !done_out;
    issue   = (state == RUN) && adv;
    hs_last = valid_out && ready_in && last_out;
  end

  always_comb begin
    state_nxt = state;
    busy_out  = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (issue && x_wrap && y_end) state_nxt = DRAIN;
      DRAIN:   if (hs_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      done_out <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      c_stride <= '0;
      cu_x <= '0; cu_y <= '0; cu_z <= '0;
      cv_x <= '0; cv_y <= '0; cv_z <= '0;
      cw_x <= '0; cw_y <= '0; cw_z <= '0;
    end else begin
      state    <= state_nxt;
      done_out <= (state == DRAIN) && hs_last;
      if (accept) begin
        x_cnt    <= '0;
        y_cnt    <= '0;
        c_stride <= stride_log2_in;
        cu_x <= u_x_in; cu_y <= u_y_in; cu_z <= u_z_in;
        cv_x <= v_x_in; cv_y <= v_y_in; cv_z <= v_z_in;
        cw_x <= w_x_in; cw_y <= w_y_in; cw_z <= w_z_in;
      end else if (issue) begin
        if (x_wrap) begin
          x_cnt <= '0;
          y_cnt <= y_sum[YW-1:0];
        end else begin
          x_cnt <= x_sum[XW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
      s1_x <= '0; s1_y <= '0; s1_xs <= '0; s1_ys <= '0;
      s2_valid <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0;
      s2_x <= '0; s2_y <= '0;
      s2_px_x <= '0; s2_px_y <= '0; s2_px_z <= '0;
      s2_py_x <= '0; s2_py_y <= '0; s2_py_z <= '0;
      valid_out <= 1'b0; first_out <= 1'b0; last_out <= 1'b0;
      x_out <= '0; y_out <= '0;
      dir_x_out <= '0; dir_y_out <= '0; dir_z_out <= '0;
    end else if (adv) begin
      s1_valid <= issue;
      s1_first <= issue && (x_cnt == '0) && (y_cnt == '0);
      s1_last  <= issue && x_wrap && y_end;
      s1_x     <= x_cnt;
      s1_y     <= y_cnt;
      s1_xs    <= $signed({1'b0, x_cnt}) - HALF_W;
      s1_ys    <= $signed({1'b0, y_cnt}) - HALF_H;

      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_x     <= s1_x;
      s2_y     <= s1_y;
      s2_px_x  <= PX_W'(s1_xs) * PX_W'(cu_x);
      s2_px_y  <= PX_W'(s1_xs) * PX_W'(cu_y);
      s2_px_z  <= PX_W'(s1_xs) * PX_W'(cu_z);
      s2_py_x  <= PY_W'(s1_ys) * PY_W'(cv_x);
      s2_py_y  <= PY_W'(s1_ys) * PY_W'(cv_y);
      s2_py_z  <= PY_W'(s1_ys) * PY_W'(cv_z);

      valid_out <= s2_valid;
      first_out <= s2_first;
      last_out  <= s2_last;
      x_out     <= s2_x;
      y_out     <= s2_y;
      dir_x_out <= shift_dir(s2_px_x, s2_py_x, cw_x);
      dir_y_out <= shift_dir(s2_px_y, s2_py_y, cw_y);
      dir_z_out <= shift_dir(s2_px_z, s2_py_z, cw_z);
    end
  end

endmodule

// File: tb/tb_ray_gen_scan.sv
// Self-checking bench for ray_gen_scan on a reduced 16x12 frame; expected beats come
// from a raster-order list and floor-division arithmetic model.
module tb_ray_gen_scan;

  localparam int W    = 16;
  localparam int H    = 12;
  localparam int XW   = 5;
  localparam int YW   = 4;
  localparam int CW   = 24;
  localparam int FRAC = 8;
  localparam int OW   = 32;

  logic          clk_in = 1'b0;
  logic          rst_in, start_in, ready_in;
  logic [1:0]    stride_log2_in;
  logic [CW-1:0] u_x_in, u_y_in, u_z_in, v_x_in, v_y_in, v_z_in, w_x_in, w_y_in, w_z_in;
  logic          busy_out, done_out, valid_out, first_out, last_out;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [OW-1:0] dir_x_out, dir_y_out, dir_z_out;

  int total = 0;
  int bad   = 0;
  int cu[3], cv[3], cw[3];
  logic [31:0] row0_dx[W];

  typedef struct {
    int          x;
    int          y;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] dz;
    bit          first;
    bit          last;
  } beat_t;

  ray_gen_scan #(
    .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .COORD_W(CW), .FRAC(FRAC), .OUT_W(OW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .stride_log2_in(stride_log2_in),
    .u_x_in(u_x_in), .u_y_in(u_y_in), .u_z_in(u_z_in),
    .v_x_in(v_x_in), .v_y_in(v_y_in), .v_z_in(v_z_in),
    .w_x_in(w_x_in), .w_y_in(w_y_in), .w_z_in(w_z_in),
    .busy_out(busy_out), .done_out(done_out), .ready_in(ready_in), .valid_out(valid_out),
    .x_out(x_out), .y_out(y_out),
    .dir_x_out(dir_x_out), .dir_y_out(dir_y_out), .dir_z_out(dir_z_out),
    .first_out(first_out), .last_out(last_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_dir(int xs, int ys, int u, int v, int w);
    longint val, q, den;
    den = longint'(1) << FRAC;
    val = longint'(xs) * longint'(u) + longint'(ys) * longint'(v) + longint'(w);
    q = val / den;
    if ((val % den) != 0 && val < 0) q = q - 1;
    return q[31:0];
  endfunction

  function automatic int sx24(int r);
    return (r <<< 8) >>> 8;
  endfunction

  task automatic rand_cfg();
    for (int i = 0; i < 3; i++) begin
      cu[i] = sx24(int'($urandom));
      cv[i] = sx24(int'($urandom));
      cw[i] = sx24(int'($urandom));
    end
  endtask

  task automatic plan_cfg();
    cu = '{256, 0, 0};
    cv = '{0, 256, 0};
    cw = '{0, 0, 102400};
  endtask

  task automatic drive_cfg();
    u_x_in = cu[0][CW-1:0]; u_y_in = cu[1][CW-1:0]; u_z_in = cu[2][CW-1:0];
    v_x_in = cv[0][CW-1:0]; v_y_in = cv[1][CW-1:0]; v_z_in = cv[2][CW-1:0];
    w_x_in = cw[0][CW-1:0]; w_y_in = cw[1][CW-1:0]; w_z_in = cw[2][CW-1:0];
  endtask

  task automatic run_frame(input int sl2, input bit rnd_ready, input bit mid_start,
                           input bit start_at_done);
    beat_t         expq[$];
    beat_t         e;
    int            s, cyc, first_cyc, last_cyc, nbeats;
    bit            got_last, stall_prev;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;
    logic [OW-1:0] hdx, hdy, hdz;

    s = 1 << sl2;
    for (int y = 0; y < H; y += s)
      for (int x = 0; x < W; x += s) begin
        e.x  = x;
        e.y  = y;
        e.dx = ref_dir(x - W/2, y - H/2, cu[0], cv[0], cw[0]);
        e.dy = ref_dir(x - W/2, y - H/2, cu[1], cv[1], cw[1]);
        e.dz = ref_dir(x - W/2, y - H/2, cu[2], cv[2], cw[2]);
        e.first = (x == 0 && y == 0);
        e.last  = 1'b0;
        expq.push_back(e);
      end
    expq[expq.size()-1].last = 1'b1;
    nbeats = expq.size();

    drive_cfg();
    stride_log2_in = sl2[1:0];
    ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    start_in = 1'b1;
    @(posedge clk_in); #1 start_in = 1'b0;
    cyc = 0; first_cyc = -1; last_cyc = -1; got_last = 0; stall_prev = 0;
    hx = '0; hy = '0; hdx = '0; hdy = '0; hdz = '0;

    while (!got_last && cyc < 5000) begin
      @(negedge clk_in);
      if (cyc == 0) chk("busy_after_start", 32'(busy_out), 32'd1);
      if (stall_prev) begin
        chk("stall_valid", 32'(valid_out), 32'd1);
        chk("stall_x", 32'(x_out), 32'(hx));
        chk("stall_y", 32'(y_out), 32'(hy));
        chk("stall_dx", dir_x_out, hdx);
        chk("stall_dy", dir_y_out, hdy);
        chk("stall_dz", dir_z_out, hdz);
      end
      if (valid_out && first_cyc < 0) first_cyc = cyc;
      if (valid_out && ready_in) begin
        if (expq.size() == 0) begin
          chk("beat_overrun", 32'(valid_out), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("beat_x", 32'(x_out), e.x);
          chk("beat_y", 32'(y_out), e.y);
          chk("beat_dx", dir_x_out, e.dx);
          chk("beat_dy", dir_y_out, e.dy);
          chk("beat_dz", dir_z_out, e.dz);
          chk("beat_first", 32'(first_out), 32'(e.first));
          chk("beat_last", 32'(last_out), 32'(e.last));
          if (e.y == 0) row0_dx[e.x] = dir_x_out;
          if (e.last) begin
            got_last = 1;
            last_cyc = cyc;
          end
        end
      end
      stall_prev = valid_out && !ready_in;
      hx = x_out; hy = y_out; hdx = dir_x_out; hdy = dir_y_out; hdz = dir_z_out;
      @(posedge clk_in); #1;
      cyc++;
      if (rnd_ready) ready_in = 1'($urandom_range(0, 1));
      if (mid_start && cyc == 8) begin
        start_in = 1'b1;
        u_x_in = ~u_x_in;
        v_y_in = v_y_in + 1'b1;
        w_z_in = '0;
        stride_log2_in = ~stride_log2_in;
      end else begin
        start_in = 1'b0;
      end
    end

    chk("beats_remaining", 32'(expq.size()), 32'd0);
    chk("first_latency", 32'(first_cyc), 32'd3);
    if (!rnd_ready) chk("no_bubbles", 32'(last_cyc - first_cyc), 32'(nbeats - 1));

    if (start_at_done) start_in = 1'b1;
    @(negedge clk_in);
    chk("done_pulse", 32'(done_out), 32'd1);
    chk("busy_at_done", 32'(busy_out), 32'd0);
    chk("valid_at_done", 32'(valid_out), 32'd0);
    @(posedge clk_in); #1 start_in = 1'b0;
    @(negedge clk_in);
    chk("done_single", 32'(done_out), 32'd0);
    chk("idle_after_done", 32'(busy_out), 32'd0);
    ready_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b1; stride_log2_in = '0;
    cu = '{0, 0, 0}; cv = '{0, 0, 0}; cw = '{0, 0, 0};
    drive_cfg();
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_first", 32'(first_out), 32'd0);
    chk("rst_last", 32'(last_out), 32'd0);
    chk("rst_dx", dir_x_out, 32'd0);
    chk("rst_x", 32'(x_out), 32'd0);
    @(posedge clk_in); #1;

    // Reference camera, full frame then stride 4
    plan_cfg();
    run_frame(0, 0, 0, 0);
    chk("plan_dx_origin", row0_dx[0], 32'hFFFF_FFF8);
    run_frame(2, 0, 0, 0);

    // Random cameras under random back-pressure
    rand_cfg(); run_frame(0, 1, 0, 0);
    rand_cfg(); run_frame(1, 1, 0, 1);
    rand_cfg(); run_frame(3, 1, 0, 0);

    // Negative half must floor toward -inf
    cu = '{-128, 0, 0}; cv = '{0, 0, 0}; cw = '{0, 0, 0};
    run_frame(0, 0, 0, 0);
    chk("neg_floor_x9", row0_dx[9], 32'hFFFF_FFFF);
    chk("neg_floor_x7", row0_dx[7], 32'd0);
    chk("neg_floor_x1", row0_dx[1], 32'd3);

    // Start pulse and config churn during RUN are ignored
    rand_cfg(); run_frame(0, 1, 1, 0);

    // Reset while stalled aborts the frame
    plan_cfg(); drive_cfg();
    stride_log2_in = 2'd0; ready_in = 1'b1; start_in = 1'b1;
    @(posedge clk_in); #1 start_in = 1'b0;
    repeat (6) @(posedge clk_in);
    #1 ready_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("stalled_before_rst", 32'(valid_out), 32'd1);
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("abort_valid", 32'(valid_out), 32'd0);
    chk("abort_busy", 32'(busy_out), 32'd0);
    chk("abort_done", 32'(done_out), 32'd0);
    @(posedge clk_in); #1 ready_in = 1'b1;
    run_frame(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
